// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
// Holds the receive FSM state encoding, the oversampling constants and
// the default prescaler divide value used by uart_baud_tick.
// Optional feature macro: UART_RX_PARITY_EN.
// When it is defined, the PARITY state is used and even parity is checked.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // One serial bit lasts this many 16x ticks.
    localparam int TICKS_PER_BIT = 16;

    // The middle of the start bit is the eighth tick, which is count value 7.
    localparam logic [3:0] MID_SAMPLE = 4'd7;

    // 50 MHz / (2*(0x1A+1)*16) gives roughly 57600 baud.
    localparam logic [7:0] DEFAULT_CLK_DIV = 8'h1A;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Prescaler that produces the 16x oversampling tick for the UART.
// The counter runs from 0 to 2*(CLK_DIV+1)-1, and tick16x is high for one
// clock at the terminal count. A synchronous clear restarts it at 0. The
// receiver uses the clear to align the ticks with a start edge. The
// transmit path is meant to reuse this block as well.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   clear    in   synchronous restart of the prescaler count
//   tick16x  out  one-clock pulse at 16x the baud rate
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter logic [7:0] CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick16x
);

    localparam int         TERM_I = 2 * (int'(CLK_DIV) + 1) - 1;
    localparam logic [8:0] TERM   = TERM_I[8:0];

    logic [8:0] count;

    // The free-running divide counter. It wraps at the terminal count, and
    // a clear request always wins so that a new frame starts from a clean
    // phase no matter where the count happened to be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 9'd0;
        end else if (clear) begin
            count <= 9'd0;
        end else if (count == TERM) begin
            count <= 9'd0;
        end else begin
            count <= count + 9'd1;
        end
    end

    assign tick16x = (count == TERM);

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// Receive front end of the UART core. The block does the following:
//   - synchronises rxin;
//   - detects the falling edge of the start bit;
//   - samples each bit at its mid-point using the 16x tick;
//   - hands each completed byte downstream through a valid/ready holding register.
// Errors are reported as one-clock pulses:
//   - frame_err when the stop bit is sampled low;
//   - overrun when a byte completes while the holding register is still full.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after the data bits.
// A mismatch pulses parity_err. Without the macro, parity_err is tied 0.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   rxin        in   serial line, idle high
//   rx_data     out  received byte, stable while rx_valid=1
//   rx_valid    out  byte available
//   rx_ready    in   consumer accepts when rx_valid & rx_ready
//   frame_err   out  pulse: stop bit sampled 0
//   overrun     out  pulse: byte completed while holding register full
//   parity_err  out  pulse: parity mismatch
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter logic [7:0] CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int         DATA_BITS   = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int             BCW       = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_TICK = 4'(TICKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] syncFf;
    logic                   rxSync;
    logic                   rxPrev;
    logic                   startEdge;
    rx_state_t              state;
    rx_state_t              nextState;
    logic                   tick16x;
    logic [3:0]             tickCnt;
    logic [BCW-1:0]         bitCnt;
    logic [DATA_BITS-1:0]   shiftReg;
    logic                   midSample;
    logic                   bitSample;
    logic                   prescClear;
    logic                   clearTick;
    logic                   shiftEn;
    logic                   byteDone;
    logic                   stopFail;
`ifdef UART_RX_PARITY_EN
    logic                   parityLoad;
    logic                   parityBad;
`endif

    // The metastability chain and the edge detector both reset to 1 (idle
    // line). Because of that, coming out of reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncFf <= '1;
            rxPrev <= 1'b1;
        end else begin
            syncFf <= {syncFf[SYNC_STAGES-2:0], rxin};
            rxPrev <= rxSync;
        end
    end

    assign rxSync    = syncFf[SYNC_STAGES-1];
    assign startEdge = rxPrev & ~rxSync;
    assign midSample = tick16x & (tickCnt == MID_SAMPLE);
    assign bitSample = tick16x & (tickCnt == LAST_TICK);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) baudTick (
        .clk     (clk),
        .reset   (reset),
        .clear   (prescClear),
        .tick16x (tick16x)
    );

    // State register for the receive FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. A start bit that is high again at its mid-point is
    // treated as a glitch and dropped silently. A low stop bit parks the FSM
    // in BREAK until the line recovers, so a held-low line reports one error.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (startEdge) nextState = START;
            START:  if (midSample) nextState = rxSync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bitSample && (bitCnt == LAST_BIT)) nextState = PARITY;
            PARITY: if (bitSample) nextState = STOP;
`else
            DATA:   if (bitSample && (bitCnt == LAST_BIT)) nextState = STOP;
`endif
            STOP:   if (bitSample) nextState = rxSync ? IDLE : BREAK;
            BREAK:  if (rxSync) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM control outputs. The tick counter is held at zero while idle and
    // is rezeroed at the start-bit mid-point. After that it wraps naturally
    // every 16 ticks, so every later sample lands mid-bit.
    always_comb begin
        prescClear = 1'b0;
        clearTick  = 1'b0;
        shiftEn    = 1'b0;
        byteDone   = 1'b0;
        stopFail   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityLoad = 1'b0;
`endif
        case (state)
            IDLE: begin
                clearTick  = 1'b1;
                prescClear = startEdge;
            end
            START:  clearTick = midSample;
            DATA:   shiftEn   = bitSample;
`ifdef UART_RX_PARITY_EN
            PARITY: parityLoad = bitSample;
`endif
            STOP: begin
                byteDone = bitSample & rxSync;
                stopFail = bitSample & ~rxSync;
            end
            default: ;
        endcase
    end

    // Bit-level datapath: the tick counter, the data bit counter and the
    // LSB-first shift register. With parity enabled, the parity check result
    // is also latched here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickCnt  <= 4'd0;
            bitCnt   <= '0;
            shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
            parityBad <= 1'b0;
`endif
        end else begin
            if (clearTick) begin
                tickCnt <= 4'd0;
            end else if (tick16x) begin
                tickCnt <= tickCnt + 4'd1;
            end
            if (state != DATA) begin
                bitCnt <= '0;
            end else if (shiftEn) begin
                bitCnt <= bitCnt + BCW'(1);
            end
            if (shiftEn) begin
                shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (parityLoad) begin
                parityBad <= rxSync ^ (^shiftReg);
            end
`endif
        end
    end

    // Holding register and error pulses. A new byte may load in the same
    // cycle that the consumer takes the old one. If the register is full and
    // not being drained, the new byte is dropped and overrun is flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err <= stopFail;
            overrun   <= byteDone & rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= byteDone & parityBad;
`else
            parity_err <= 1'b0;
`endif
            if (byteDone && (!rx_valid || rx_ready)) begin
                rx_data  <= shiftReg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
// Directed testbench for uart_rx_deser at the default 57600 baud timing
// (one bit = 864 clk). A table of single frames is applied in a loop,
// followed by hand-written sequences for the following cases:
//   - reset mid-frame;
//   - a start glitch;
//   - back-to-back overrun;
//   - parity, when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deser;

    localparam int BIT_CLKS = 864;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       rxReady;
        int         expRise;
        int         expFerr;
        int         expHigh;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxin;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int assertCount = 0;
    int failCount   = 0;

    int         riseCnt      = 0;
    int         validHighCnt = 0;
    int         ferrCnt      = 0;
    int         ovrCnt       = 0;
    int         perrCnt      = 0;
    int         perrAtRise   = 0;
    logic [7:0] lastData     = 8'h00;
    logic       prevValid    = 1'b0;

    int r0, h0, f0, o0, p0, pr0;

    vec_t vecs[3];

    always #10 clk = ~clk;

    uart_rx_deser dut (
        .clk        (clk),
        .reset      (reset),
        .rxin       (rxin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Event monitor: counts rx_valid rises (capturing the byte), cycles of
    // rx_valid high, and cycles of each error pulse, sampled on the falling edge.
    always @(negedge clk) begin
        prevValid <= rx_valid;
        if (rx_valid && !prevValid) begin
            riseCnt  <= riseCnt + 1;
            lastData <= rx_data;
            if (parity_err) perrAtRise <= perrAtRise + 1;
        end
        if (rx_valid)   validHighCnt <= validHighCnt + 1;
        if (frame_err)  ferrCnt      <= ferrCnt + 1;
        if (overrun)    ovrCnt       <= ovrCnt + 1;
        if (parity_err) perrCnt      <= perrCnt + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b, input int clks);
        rxin = b;
        waitClks(clks);
    endtask

    task automatic snapshot();
        r0  = riseCnt;
        h0  = validHighCnt;
        f0  = ferrCnt;
        o0  = ovrCnt;
        p0  = perrCnt;
        pr0 = perrAtRise;
    endtask

    // Drive one serial frame: start bit, LSB-first data, optional parity, stop bit.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parityBit);
        logic [7:0] sh;
        sh = d;
        sendBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            sendBit(sh[0], BIT_CLKS);
            sh = sh >> 1;
        end
`ifdef UART_RX_PARITY_EN
        sendBit(parityBit, BIT_CLKS);
`else
        if (parityBit === 1'bx) $display("[TB] parity bit unknown");
`endif
        sendBit(stopBit, BIT_CLKS);
    endtask

    initial begin
        vecs[0] = '{data: 8'h39, stopBit: 1'b1, rxReady: 1'b1, expRise: 1, expFerr: 0, expHigh: 1};
        vecs[1] = '{data: 8'h55, stopBit: 1'b0, rxReady: 1'b1, expRise: 0, expFerr: 1, expHigh: 0};
        vecs[2] = '{data: 8'h0F, stopBit: 1'b1, rxReady: 1'b0, expRise: 1, expFerr: 0, expHigh: -1};

        reset    = 1'b1;
        rxin     = 1'b1;
        rx_ready = 1'b1;
        waitClks(4);
        $display("[TB] reset state");
        checkOutput("reset rx_valid",   int'(rx_valid),   0);
        checkOutput("reset rx_data",    int'(rx_data),    0);
        checkOutput("reset frame_err",  int'(frame_err),  0);
        checkOutput("reset overrun",    int'(overrun),    0);
        checkOutput("reset parity_err", int'(parity_err), 0);
        reset = 1'b0;
        waitClks(20);

        // Table of single frames. The held-low stop bit case keeps the line
        // low for three more bit times before releasing it.
        for (int i = 0; i < 3; i++) begin
            $display("[TB] vector %0d data 0x%02h", i, vecs[i].data);
            rx_ready = vecs[i].rxReady;
            snapshot();
            applyStimulus(vecs[i].data, vecs[i].stopBit, ^vecs[i].data);
            if (!vecs[i].stopBit) sendBit(1'b0, 3 * BIT_CLKS);
            sendBit(1'b1, 100);
            checkOutput("vec rx_valid rises", riseCnt - r0, vecs[i].expRise);
            checkOutput("vec frame_err pulses", ferrCnt - f0, vecs[i].expFerr);
            checkOutput("vec overrun pulses", ovrCnt - o0, 0);
            checkOutput("vec parity_err pulses", perrCnt - p0, 0);
            if (vecs[i].expRise > 0) checkOutput("vec rx_data", int'(lastData), int'(vecs[i].data));
            if (vecs[i].expHigh >= 0) checkOutput("vec rx_valid high cycles", validHighCnt - h0, vecs[i].expHigh);
        end

        // Reset in the middle of data bit 4 of 0xFF while 0x0F is still held.
        $display("[TB] reset mid-frame");
        checkOutput("held rx_valid before reset", int'(rx_valid), 1);
        sendBit(1'b0, BIT_CLKS);
        sendBit(1'b1, 4 * BIT_CLKS + BIT_CLKS / 2);
        reset = 1'b1;
        #1;
        checkOutput("midreset rx_valid", int'(rx_valid), 0);
        checkOutput("midreset rx_data",  int'(rx_data),  0);
        checkOutput("midreset frame_err", int'(frame_err), 0);
        checkOutput("midreset overrun",  int'(overrun),  0);
        waitClks(3);
        reset    = 1'b0;
        rx_ready = 1'b1;
        waitClks(BIT_CLKS);
        snapshot();
        applyStimulus(8'h81, 1'b1, 1'b0);
        sendBit(1'b1, 100);
        checkOutput("after reset rises", riseCnt - r0, 1);
        checkOutput("after reset rx_data", int'(lastData), 8'h81);
        checkOutput("after reset frame_err", ferrCnt - f0, 0);

        // A 5-tick low glitch on an idle line must not produce anything.
        $display("[TB] start glitch");
        snapshot();
        sendBit(1'b0, 270);
        sendBit(1'b1, 2 * BIT_CLKS);
        checkOutput("glitch rises", riseCnt - r0, 0);
        checkOutput("glitch frame_err", ferrCnt - f0, 0);
        checkOutput("glitch overrun", ovrCnt - o0, 0);
        checkOutput("glitch parity_err", perrCnt - p0, 0);

        // Two back-to-back frames with the consumer stalled.
        $display("[TB] overrun");
        rx_ready = 1'b0;
        snapshot();
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        sendBit(1'b1, 100);
        checkOutput("overrun rises", riseCnt - r0, 1);
        checkOutput("overrun held rx_data", int'(rx_data), 8'hA5);
        checkOutput("overrun held rx_valid", int'(rx_valid), 1);
        checkOutput("overrun pulses", ovrCnt - o0, 1);
        checkOutput("overrun frame_err", ferrCnt - f0, 0);
        rx_ready = 1'b1;
        waitClks(1);
        checkOutput("ready drops rx_valid", int'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even parity 0. A parity bit of 1 is a mismatch.
        $display("[TB] parity");
        snapshot();
        applyStimulus(8'h03, 1'b1, 1'b1);
        sendBit(1'b1, 100);
        checkOutput("bad parity rises", riseCnt - r0, 1);
        checkOutput("bad parity rx_data", int'(lastData), 8'h03);
        checkOutput("bad parity pulses", perrCnt - p0, 1);
        checkOutput("bad parity with valid", perrAtRise - pr0, 1);
        snapshot();
        applyStimulus(8'h03, 1'b1, 1'b0);
        sendBit(1'b1, 100);
        checkOutput("good parity rises", riseCnt - r0, 1);
        checkOutput("good parity pulses", perrCnt - p0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
